load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Parametrised memory-stage load/store unit for the RV pipeline. Generalises the fixed 32-bit load/store funct3 handling to XLEN = 32 or 64. It adds:
- LD/SD/LWU when XLEN = 64
- byte-enable generation and lane alignment
- sign/zero extension
- misalignment and illegal-funct3 detection
- a registered valid/ready request and response interface toward a single-outstanding memory port, with timeout and flush.

Parameters:
XLEN, 32, data/register width; legal values 32 or 64.
ADDR_WIDTH, 32, byte address width.
TIMEOUT_CYCLES, 0, maximum MEM_WAIT cycles before a timeout error; 0 disables the timeout.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
flush  in  1  kill in-flight operation (pipeline redirect)
req_valid  in  1  pipeline request valid
req_ready  out  1  unit can accept a request
req_is_store  in  1  1 = store, 0 = load
req_funct3  in  3  RISC-V load/store funct3
req_address  in  ADDR_WIDTH  effective byte address
req_store_data  in  XLEN  rs2 value
req_rd  in  5  destination register tag
resp_valid  out  1  result valid
resp_ready  in  1  writeback accepts result
resp_load_data  out  XLEN  extended load data; 0 for stores and errors
resp_rd  out  5  echoed req_rd
resp_error  out  3  lsu_error_t code
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_we  out  1  write enable
mem_address  out  ADDR_WIDTH  address aligned down to XLEN/8
mem_wdata  out  XLEN  lane-shifted store data
mem_byte_enable  out  XLEN/8  active byte lanes
mem_rsp_valid  in  1  memory response valid
mem_rsp_data  in  XLEN  full-word read data
mem_rsp_error  in  1  bus error

Behaviour:
- Clock, reset and outputs
  - One clock domain (clk).
  - Reset is asynchronous, active-low (reset_n).
  - On reset: state IDLE; all registered outputs 0 (resp_*, mem_*, captured fields).
- req_ready
  - req_ready = (state == IDLE) && !flush.
  - Accept occurs when req_valid && req_ready.
- FSM: IDLE, MEM_REQ, MEM_WAIT, RESPOND
  - IDLE, on accept: latch the request.
    - Illegal funct3 -> RESPOND with ILLEGAL.
    - Misaligned address -> RESPOND with MISALIGNED.
    - No memory request is issued in either case.
    - Otherwise -> MEM_REQ.
  - MEM_REQ: mem_req_valid = 1; address, wdata, byte-enable and we stay stable until mem_req_ready; then -> MEM_WAIT.
  - MEM_WAIT: wait-cycle counter runs.
    - mem_rsp_valid -> RESPOND; error BUS if mem_rsp_error, else NONE.
    - TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1 with no response -> RESPOND with TIMEOUT.
  - RESPOND: resp_valid = 1, outputs held stable until resp_ready; then -> IDLE.
- Minimum latency: accept at cycle 0, mem_req_valid at cycle 1, response at cycle 2, resp_valid at cycle 3. Error shortcut: resp_valid at cycle 1.
- Legal funct3
  - Loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU; plus 3 LD and 6 LWU only when XLEN = 64.
  - Stores: 0 SB, 1 SH, 2 SW; plus 3 SD only when XLEN = 64.
  - All others are ILLEGAL.
- Alignment: access size of B/H/W/D = 1/2/4/8 bytes. Misaligned when address mod size != 0.
- Lanes
  - offset = address mod (XLEN/8).
  - mem_byte_enable = ((1 << size) - 1) << offset.
  - mem_wdata = store_data << (8*offset).
  - Loads: raw = mem_rsp_data >> (8*offset), then truncate to size.
  - Sign-extend for LB/LH/LW (LW only when XLEN = 64); zero-extend for LBU/LHU/LWU.
- Stores return resp_load_data = 0.
- Errors: lsu_error_t NONE=0, MISALIGNED=1, ILLEGAL=2, BUS=3, TIMEOUT=4.
- Flush
  - IDLE: request not accepted.
  - MEM_REQ before the handshake: abort -> IDLE, and the request is withdrawn.
  - MEM_REQ with the handshake in the same cycle, or in MEM_WAIT: set the killed flag and keep waiting for the response or timeout. Then -> IDLE without resp_valid.
  - RESPOND: drop the response -> IDLE.
- Late responses: any mem_rsp_valid outside MEM_WAIT is ignored, including after a timeout.
- Reset mid-operation: immediate IDLE; in-flight data is lost.

Decomposition:
- Additions to the shared common package:
  - lsu_error_t
  - lsu_state_t
  - access-size typedef
  - LD/SD/LWU funct3 constants
- One combinational sub-module, lsu_lane_align: given offset, size and signedness, produces byte-enable, shifted wdata and extended load data.

Test Plan:
- XLEN=32, LB @0x1003, mem_rsp_data 0x80ABCDEF -> mem_address 0x1000, be 4'b1000, resp_load_data 0xFFFFFF80. Same with LBU -> 0x00000080.
- SH @0x2002, data 0x12345678 -> mem_we 1, mem_address 0x2000, be 4'b1100, wdata 0x56780000; after the response, resp_valid with data 0 and error NONE.
- LW @0x1002 -> no mem_req_valid; resp_valid at cycle 1 with MISALIGNED. funct3=3 with XLEN=32 -> ILLEGAL.
- TIMEOUT_CYCLES=4, mem_req_ready=1, no response -> resp_error TIMEOUT after 4 MEM_WAIT cycles. A response arriving 2 cycles later is ignored and req_ready stays 1.
- Flush in MEM_WAIT, response 3 cycles later -> resp_valid never asserts; req_ready returns 1 the cycle after the response.
- XLEN=64, LWU @0x4, rsp 0xFFFFFFFF_00000000 -> 0x00000000_FFFFFFFF. Hold resp_ready=0 for 5 cycles -> resp outputs stable and req_ready 0 throughout.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared load/store types: error codes, FSM states, access sizes and funct3 decode helpers.
// Combinational helpers only; no latency and no backpressure.
package load_store_unit_pkg;

    typedef enum logic [2:0] {
        LSU_ERR_NONE       = 3'd0,
        LSU_ERR_MISALIGNED = 3'd1,
        LSU_ERR_ILLEGAL    = 3'd2,
        LSU_ERR_BUS        = 3'd3,
        LSU_ERR_TIMEOUT    = 3'd4
    } lsu_error_t;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_MEM_REQ,
        LSU_MEM_WAIT,
        LSU_RESPOND
    } lsu_state_t;

    typedef enum logic [1:0] {
        LSU_SZ_B = 2'd0,
        LSU_SZ_H = 2'd1,
        LSU_SZ_W = 2'd2,
        LSU_SZ_D = 2'd3
    } lsu_size_t;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LD  = 3'd3;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_LWU = 3'd6;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;
    localparam logic [2:0] F3_SD  = 3'd3;

    function automatic logic funct3_legal(input logic is_store, input logic [2:0] f3,
                                          input logic rv64);
        if (is_store) begin
            return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW) || (rv64 && (f3 == F3_SD));
        end
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) || (f3 == F3_LBU) ||
               (f3 == F3_LHU) || (rv64 && ((f3 == F3_LD) || (f3 == F3_LWU)));
    endfunction

    function automatic logic misaligned(input lsu_size_t sz, input logic [2:0] low);
        case (sz)
            LSU_SZ_B: return 1'b0;
            LSU_SZ_H: return low[0];
            LSU_SZ_W: return |low[1:0];
            default:  return |low;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: byte enables and shifted store data from offset/size, extended load data from a full word.
// Purely combinational, zero latency; no flow control.
module lsu_lane_align
    import load_store_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [$clog2(XLEN/8)-1:0] offset_i,
    input  lsu_size_t                 size_i,
    input  logic                      is_signed_i,
    input  logic [XLEN-1:0]           store_data_i,
    input  logic [XLEN-1:0]           rsp_data_i,
    output logic [XLEN/8-1:0]         byte_enable_o,
    output logic [XLEN-1:0]           wdata_o,
    output logic [XLEN-1:0]           load_data_o
);

    localparam int NB = XLEN / 8;

    logic [NB-1:0]   mask;
    logic [XLEN-1:0] raw;

    always_comb begin
        mask = '0;
        case (size_i)
            LSU_SZ_B: mask = NB'(1);
            LSU_SZ_H: mask = NB'(3);
            LSU_SZ_W: mask = NB'(15);
            default:  mask = '1;
        endcase
        byte_enable_o = mask << offset_i;
        wdata_o       = store_data_i << {offset_i, 3'b000};
        raw           = rsp_data_i >> {offset_i, 3'b000};

        // Size casts of a signed operand sign-extend; unsigned ones zero-extend.
        case (size_i)
            LSU_SZ_B: load_data_o = is_signed_i ? XLEN'($signed(raw[7:0]))  : XLEN'(raw[7:0]);
            LSU_SZ_H: load_data_o = is_signed_i ? XLEN'($signed(raw[15:0])) : XLEN'(raw[15:0]);
            LSU_SZ_W: load_data_o = is_signed_i ? XLEN'($signed(raw[31:0])) : XLEN'(raw[31:0]);
            default:  load_data_o = raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit, one outstanding access; accept->resp_valid 3 cycles min (1 on decode error).
// Holds mem_* until mem_req_ready and resp_* until resp_ready; req_ready is low whenever not IDLE.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_store,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_address,
    input  logic [XLEN-1:0]       req_store_data,
    input  logic [4:0]            req_rd,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [XLEN-1:0]       resp_load_data,
    output logic [4:0]            resp_rd,
    output logic [2:0]            resp_error,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [XLEN-1:0]       mem_wdata,
    output logic [XLEN/8-1:0]     mem_byte_enable,
    input  logic                  mem_rsp_valid,
    input  logic [XLEN-1:0]       mem_rsp_data,
    input  logic                  mem_rsp_error
);

    localparam int   NB    = XLEN / 8;
    localparam int   OFF_W = $clog2(NB);
    localparam int   CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic RV64  = (XLEN == 64);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    lsu_state_t            state_q, state_d;
    lsu_error_t            err_q, err_d;
    logic                  killed_q, killed_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic                  signed_q, signed_d;
    lsu_size_t             size_q, size_d;
    logic [OFF_W-1:0]      off_q, off_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [XLEN-1:0]       wdata_q, wdata_d;
    logic [NB-1:0]         be_q, be_d;
    logic [4:0]            rd_q, rd_d;
    logic [XLEN-1:0]       rdata_q, rdata_d;

    lsu_size_t        req_size, al_size;
    logic [OFF_W-1:0] al_off;
    logic [NB-1:0]    al_be;
    logic [XLEN-1:0]  al_wdata, al_load;
    logic             kill_now;

    assign req_size = lsu_size_t'(req_funct3[1:0]);
    // In IDLE the aligner steers the incoming store; afterwards it extends the captured load.
    assign al_off   = (state_q == LSU_IDLE) ? req_address[OFF_W-1:0] : off_q;
    assign al_size  = (state_q == LSU_IDLE) ? req_size : size_q;

    lsu_lane_align #(.XLEN(XLEN)) u_align (
        .offset_i      (al_off),
        .size_i        (al_size),
        .is_signed_i   (signed_q),
        .store_data_i  (req_store_data),
        .rsp_data_i    (mem_rsp_data),
        .byte_enable_o (al_be),
        .wdata_o       (al_wdata),
        .load_data_o   (al_load)
    );

    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        killed_d = killed_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        signed_d = signed_q;
        size_d   = size_q;
        off_d    = off_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        rd_d     = rd_q;
        rdata_d  = rdata_q;
        kill_now = killed_q || flush;

        case (state_q)
            LSU_IDLE: begin
                if (req_valid && req_ready) begin
                    we_d     = req_is_store;
                    signed_d = !req_funct3[2];
                    size_d   = req_size;
                    off_d    = req_address[OFF_W-1:0];
                    addr_d   = {req_address[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                    wdata_d  = al_wdata;
                    be_d     = al_be;
                    rd_d     = req_rd;
                    rdata_d  = '0;
                    cnt_d    = '0;
                    killed_d = 1'b0;
                    if (!funct3_legal(req_is_store, req_funct3, RV64)) begin
                        err_d   = LSU_ERR_ILLEGAL;
                        state_d = LSU_RESPOND;
                    end else if (misaligned(req_size, req_address[2:0])) begin
                        err_d   = LSU_ERR_MISALIGNED;
                        state_d = LSU_RESPOND;
                    end else begin
                        err_d   = LSU_ERR_NONE;
                        state_d = LSU_MEM_REQ;
                    end
                end
            end
            LSU_MEM_REQ: begin
                // Once accepted by memory a flush cannot withdraw it; drain it silently instead.
                if (mem_req_ready) begin
                    state_d  = LSU_MEM_WAIT;
                    cnt_d    = '0;
                    killed_d = flush;
                end else if (flush) begin
                    state_d = LSU_IDLE;
                end
            end
            LSU_MEM_WAIT: begin
                if (mem_rsp_valid) begin
                    state_d = kill_now ? LSU_IDLE : LSU_RESPOND;
                    err_d   = mem_rsp_error ? LSU_ERR_BUS : LSU_ERR_NONE;
                    rdata_d = (we_q || mem_rsp_error) ? '0 : al_load;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST)) begin
                    state_d = kill_now ? LSU_IDLE : LSU_RESPOND;
                    err_d   = LSU_ERR_TIMEOUT;
                    rdata_d = '0;
                end else begin
                    cnt_d    = cnt_q + CNT_W'(1);
                    killed_d = kill_now;
                end
            end
            LSU_RESPOND: begin
                if (flush || resp_ready) begin
                    state_d = LSU_IDLE;
                end
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= LSU_IDLE;
            err_q    <= LSU_ERR_NONE;
            killed_q <= 1'b0;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            signed_q <= 1'b0;
            size_q   <= LSU_SZ_B;
            off_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            rd_q     <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            killed_q <= killed_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            signed_q <= signed_d;
            size_q   <= size_d;
            off_q    <= off_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            rd_q     <= rd_d;
            rdata_q  <= rdata_d;
        end
    end

    assign req_ready       = (state_q == LSU_IDLE) && !flush;
    assign resp_valid      = (state_q == LSU_RESPOND);
    assign resp_load_data  = rdata_q;
    assign resp_rd         = rd_q;
    assign resp_error      = err_q;
    assign mem_req_valid   = (state_q == LSU_MEM_REQ);
    assign mem_we          = we_q;
    assign mem_address     = addr_q;
    assign mem_wdata       = wdata_q;
    assign mem_byte_enable = be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench: dut 0 is XLEN=32 with a 4-cycle timeout, dut 1 is XLEN=64 without timeout.
module tb_load_store_unit;

    localparam logic [2:0] E_NONE = 3'd0, E_MIS = 3'd1, E_ILL = 3'd2, E_BUS = 3'd3, E_TO = 3'd4;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  rd;
        logic [2:0]  err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  flush, req_valid, resp_ready, mem_rsp_valid;
    logic        req_is_store, mem_rsp_error, mem_req_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_address;
    logic [63:0] req_store_data, mem_rsp_data;
    logic [4:0]  req_rd;

    logic        a_req_ready, a_resp_valid, a_mem_req_valid, a_we;
    logic        b_req_ready, b_resp_valid, b_mem_req_valid, b_we;
    logic [31:0] a_resp_data, a_wdata, a_addr, b_addr;
    logic [63:0] b_resp_data, b_wdata;
    logic [3:0]  a_be;
    logic [7:0]  b_be;
    logic [4:0]  a_rd, b_rd;
    logic [2:0]  a_err, b_err;

    exp_t q0[$];
    exp_t q1[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   tag      = 1;

    always #5 clk = ~clk;

    load_store_unit #(.XLEN(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut32 (
        .clk(clk), .reset_n(reset_n), .flush(flush[0]), .req_valid(req_valid[0]),
        .req_ready(a_req_ready), .req_is_store(req_is_store), .req_funct3(req_funct3),
        .req_address(req_address), .req_store_data(req_store_data[31:0]), .req_rd(req_rd),
        .resp_valid(a_resp_valid), .resp_ready(resp_ready[0]), .resp_load_data(a_resp_data),
        .resp_rd(a_rd), .resp_error(a_err), .mem_req_valid(a_mem_req_valid),
        .mem_req_ready(mem_req_ready), .mem_we(a_we), .mem_address(a_addr), .mem_wdata(a_wdata),
        .mem_byte_enable(a_be), .mem_rsp_valid(mem_rsp_valid[0]),
        .mem_rsp_data(mem_rsp_data[31:0]), .mem_rsp_error(mem_rsp_error)
    );

    load_store_unit #(.XLEN(64), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(0)) dut64 (
        .clk(clk), .reset_n(reset_n), .flush(flush[1]), .req_valid(req_valid[1]),
        .req_ready(b_req_ready), .req_is_store(req_is_store), .req_funct3(req_funct3),
        .req_address(req_address), .req_store_data(req_store_data), .req_rd(req_rd),
        .resp_valid(b_resp_valid), .resp_ready(resp_ready[1]), .resp_load_data(b_resp_data),
        .resp_rd(b_rd), .resp_error(b_err), .mem_req_valid(b_mem_req_valid),
        .mem_req_ready(mem_req_ready), .mem_we(b_we), .mem_address(b_addr), .mem_wdata(b_wdata),
        .mem_byte_enable(b_be), .mem_rsp_valid(mem_rsp_valid[1]),
        .mem_rsp_data(mem_rsp_data), .mem_rsp_error(mem_rsp_error)
    );

    function automatic logic g_req_ready(input int s);   return s == 0 ? a_req_ready : b_req_ready; endfunction
    function automatic logic g_resp_valid(input int s);  return s == 0 ? a_resp_valid : b_resp_valid; endfunction
    function automatic logic g_mem_valid(input int s);   return s == 0 ? a_mem_req_valid : b_mem_req_valid; endfunction
    function automatic logic g_we(input int s);          return s == 0 ? a_we : b_we; endfunction
    function automatic logic [31:0] g_addr(input int s); return s == 0 ? a_addr : b_addr; endfunction
    function automatic logic [7:0] g_be(input int s);    return s == 0 ? {4'b0, a_be} : b_be; endfunction
    function automatic logic [63:0] g_wdata(input int s); return s == 0 ? {32'b0, a_wdata} : b_wdata; endfunction
    function automatic logic [63:0] g_data(input int s); return s == 0 ? {32'b0, a_resp_data} : b_resp_data; endfunction
    function automatic logic [4:0] g_rd(input int s);    return s == 0 ? a_rd : b_rd; endfunction
    function automatic logic [2:0] g_err(input int s);   return s == 0 ? a_err : b_err; endfunction

    task automatic chk(input int s, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL dut%0d %s: got 0x%0h, expected 0x%0h", s, name, act, exp);
    endtask

    task automatic check_resp(input int s);
        exp_t e;
        int   depth;
        depth = (s == 0) ? q0.size() : q1.size();
        if (depth == 0) begin
            n_checks++;
            $display("FAIL dut%0d unexpected_resp: got rd %0d err %0d, expected no response",
                     s, g_rd(s), g_err(s));
        end else begin
            if (s == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            chk(s, "resp_data", g_data(s), e.data);
            chk(s, "resp_rd", {59'b0, g_rd(s)}, {59'b0, e.rd});
            chk(s, "resp_error", {61'b0, g_err(s)}, {61'b0, e.err});
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (a_resp_valid && resp_ready[0]) check_resp(0);
            if (b_resp_valid && resp_ready[1]) check_resp(1);
        end
    end

    task automatic push(input int s, input logic [63:0] data, input logic [4:0] rd, input logic [2:0] err);
        exp_t e;
        e.data = data;
        e.rd   = rd;
        e.err  = err;
        if (s == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Drives one accept cycle; returns one cycle later (#1 past the edge).
    task automatic issue(input int s, input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [63:0] sdata, input logic [4:0] rd);
        req_is_store   = st;
        req_funct3     = f3;
        req_address    = addr;
        req_store_data = sdata;
        req_rd         = rd;
        req_valid[s]   = 1'b1;
        @(negedge clk);
        chk(s, "req_ready_idle", {63'b0, g_req_ready(s)}, 64'd1);
        @(posedge clk); #1;
        req_valid[s] = 1'b0;
    endtask

    task automatic run_mem(input int s, input logic st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [63:0] sdata, input logic [63:0] rsp, input logic rerr,
                           input logic [31:0] e_addr, input logic [7:0] e_be, input logic [63:0] e_wdata,
                           input logic [63:0] e_data, input logic [2:0] e_err, input int hold);
        logic [4:0] rd;
        rd = tag[4:0];
        tag++;
        push(s, e_data, rd, e_err);
        issue(s, st, f3, addr, sdata, rd);
        @(negedge clk);
        chk(s, "mem_req_valid", {63'b0, g_mem_valid(s)}, 64'd1);
        chk(s, "mem_address", {32'b0, g_addr(s)}, {32'b0, e_addr});
        chk(s, "mem_byte_enable", {56'b0, g_be(s)}, {56'b0, e_be});
        chk(s, "mem_we", {63'b0, g_we(s)}, {63'b0, st});
        if (st) chk(s, "mem_wdata", g_wdata(s), e_wdata);
        @(posedge clk); #1;
        mem_rsp_valid[s] = 1'b1;
        mem_rsp_data     = rsp;
        mem_rsp_error    = rerr;
        @(negedge clk);
        chk(s, "mem_req_dropped", {63'b0, g_mem_valid(s)}, 64'd0);
        chk(s, "resp_not_early", {63'b0, g_resp_valid(s)}, 64'd0);
        @(posedge clk); #1;
        mem_rsp_valid[s] = 1'b0;
        mem_rsp_error    = 1'b0;
        resp_ready[s]    = (hold == 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk(s, "hold_resp_valid", {63'b0, g_resp_valid(s)}, 64'd1);
            chk(s, "hold_resp_data", g_data(s), e_data);
            chk(s, "hold_req_ready", {63'b0, g_req_ready(s)}, 64'd0);
            @(posedge clk); #1;
        end
        resp_ready[s] = 1'b1;
        @(negedge clk);
        chk(s, "resp_latency", {63'b0, g_resp_valid(s)}, 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic run_short(input int s, input logic st, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [2:0] e_err);
        logic [4:0] rd;
        rd = tag[4:0];
        tag++;
        push(s, 64'd0, rd, e_err);
        issue(s, st, f3, addr, 64'hFFFF_FFFF_FFFF_FFFF, rd);
        @(negedge clk);
        chk(s, "short_no_mem_req", {63'b0, g_mem_valid(s)}, 64'd0);
        chk(s, "short_resp_valid", {63'b0, g_resp_valid(s)}, 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; flush = '0; req_valid = '0; resp_ready = 2'b11; mem_rsp_valid = '0;
        req_is_store = 1'b0; req_funct3 = '0; req_address = '0; req_store_data = '0; req_rd = '0;
        mem_rsp_data = '0; mem_rsp_error = 1'b0; mem_req_ready = 1'b1;
        #1;
        for (int s = 0; s < 2; s++) begin
            chk(s, "rst_req_ready", {63'b0, g_req_ready(s)}, 64'd1);
            chk(s, "rst_resp_valid", {63'b0, g_resp_valid(s)}, 64'd0);
            chk(s, "rst_mem_req_valid", {63'b0, g_mem_valid(s)}, 64'd0);
            chk(s, "rst_mem_address", {32'b0, g_addr(s)}, 64'd0);
            chk(s, "rst_mem_be", {56'b0, g_be(s)}, 64'd0);
            chk(s, "rst_resp_data", g_data(s), 64'd0);
            chk(s, "rst_resp_error", {61'b0, g_err(s)}, 64'd0);
        end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;

        // XLEN=32 memory accesses
        run_mem(0, 0, 3'd0, 32'h1003, 64'h0, 64'h80ABCDEF, 0, 32'h1000, 8'h08, 64'h0, 64'hFFFFFF80, E_NONE, 0);
        run_mem(0, 0, 3'd4, 32'h1003, 64'h0, 64'h80ABCDEF, 0, 32'h1000, 8'h08, 64'h0, 64'h00000080, E_NONE, 0);
        run_mem(0, 1, 3'd1, 32'h2002, 64'h12345678, 64'hDEADBEEF, 0, 32'h2000, 8'h0C, 64'h56780000, 64'h0, E_NONE, 0);
        run_mem(0, 0, 3'd1, 32'h1002, 64'h0, 64'h80ABCDEF, 0, 32'h1000, 8'h0C, 64'h0, 64'hFFFF80AB, E_NONE, 0);
        run_mem(0, 0, 3'd5, 32'h1000, 64'h0, 64'h80ABCDEF, 0, 32'h1000, 8'h03, 64'h0, 64'h0000CDEF, E_NONE, 0);
        run_mem(0, 1, 3'd0, 32'h3001, 64'hA5, 64'h0, 0, 32'h3000, 8'h02, 64'h0000A500, 64'h0, E_NONE, 0);
        run_mem(0, 0, 3'd2, 32'h1004, 64'h0, 64'hCAFEF00D, 1, 32'h1004, 8'h0F, 64'h0, 64'h0, E_BUS, 0);

        // Decode-error shortcuts
        run_short(0, 0, 3'd2, 32'h1002, E_MIS);
        run_short(0, 0, 3'd3, 32'h1000, E_ILL);
        run_short(0, 1, 3'd3, 32'h1000, E_ILL);
        run_short(0, 0, 3'd6, 32'h1000, E_ILL);
        run_short(0, 1, 3'd2, 32'h2002, E_MIS);
        run_short(0, 0, 3'd1, 32'h1001, E_MIS);

        // Timeout after four MEM_WAIT cycles, then a stale response must be ignored
        push(0, 64'd0, 5'd7, E_TO);
        issue(0, 0, 3'd2, 32'h3000, 64'h0, 5'd7);
        @(negedge clk);
        chk(0, "to_mem_req_valid", {63'b0, a_mem_req_valid}, 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk(0, "to_waiting", {63'b0, a_resp_valid}, 64'd0);
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk(0, "to_resp_valid", {63'b0, a_resp_valid}, 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk(0, "to_req_ready_after", {63'b0, a_req_ready}, 64'd1);
        @(posedge clk); #1;
        mem_rsp_valid[0] = 1'b1;
        mem_rsp_data     = 64'h12345678;
        @(negedge clk);
        chk(0, "late_rsp_req_ready", {63'b0, a_req_ready}, 64'd1);
        @(posedge clk); #1;
        mem_rsp_valid[0] = 1'b0;
        @(negedge clk);
        chk(0, "late_rsp_idle", {63'b0, a_req_ready}, 64'd1);
        chk(0, "late_rsp_no_resp", {63'b0, a_resp_valid}, 64'd0);
        @(posedge clk); #1;

        // Flush in MEM_WAIT: response three cycles later is swallowed
        issue(0, 0, 3'd2, 32'h3004, 64'h0, 5'd9);
        @(negedge clk);
        chk(0, "fl_mem_req_valid", {63'b0, a_mem_req_valid}, 64'd1);
        @(posedge clk); #1;
        flush[0] = 1'b1;
        @(negedge clk);
        chk(0, "fl_no_resp", {63'b0, a_resp_valid}, 64'd0);
        @(posedge clk); #1;
        flush[0] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk(0, "fl_busy", {63'b0, a_req_ready}, 64'd0);
            @(posedge clk); #1;
        end
        mem_rsp_valid[0] = 1'b1;
        mem_rsp_data     = 64'h55555555;
        @(negedge clk);
        chk(0, "fl_busy_at_rsp", {63'b0, a_req_ready}, 64'd0);
        @(posedge clk); #1;
        mem_rsp_valid[0] = 1'b0;
        @(negedge clk);
        chk(0, "fl_ready_after_rsp", {63'b0, a_req_ready}, 64'd1);
        chk(0, "fl_resp_suppressed", {63'b0, a_resp_valid}, 64'd0);
        @(posedge clk); #1;

        // Flush in MEM_REQ before the handshake withdraws the request
        mem_req_ready = 1'b0;
        issue(0, 0, 3'd2, 32'h1008, 64'h0, 5'd11);
        @(negedge clk);
        chk(0, "ab_mem_req_valid", {63'b0, a_mem_req_valid}, 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk(0, "ab_stall_valid", {63'b0, a_mem_req_valid}, 64'd1);
        chk(0, "ab_stall_addr", {32'b0, a_addr}, 64'h1008);
        flush[0] = 1'b1;
        @(posedge clk); #1;
        flush[0]      = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        chk(0, "ab_withdrawn", {63'b0, a_mem_req_valid}, 64'd0);
        chk(0, "ab_idle", {63'b0, a_req_ready}, 64'd1);
        @(posedge clk); #1;

        // XLEN=64 accesses, including a held response
        run_mem(1, 0, 3'd6, 32'h4, 64'h0, 64'hFFFFFFFF_00000000, 0, 32'h0, 8'hF0, 64'h0,
                64'h00000000_FFFFFFFF, E_NONE, 5);
        run_mem(1, 0, 3'd3, 32'h8, 64'h0, 64'h01234567_89ABCDEF, 0, 32'h8, 8'hFF, 64'h0,
                64'h01234567_89ABCDEF, E_NONE, 0);
        run_mem(1, 1, 3'd3, 32'h10, 64'h11223344_55667788, 64'h0, 0, 32'h10, 8'hFF,
                64'h11223344_55667788, 64'h0, E_NONE, 0);
        run_mem(1, 0, 3'd2, 32'hC, 64'h0, 64'h80000000_00000000, 0, 32'h8, 8'hF0, 64'h0,
                64'hFFFFFFFF_80000000, E_NONE, 0);
        run_mem(1, 1, 3'd0, 32'h5, 64'hAB, 64'h0, 0, 32'h0, 8'h20, 64'h0000AB00_00000000,
                64'h0, E_NONE, 0);
        run_short(1, 0, 3'd3, 32'hC, E_MIS);
        run_short(1, 0, 3'd7, 32'h8, E_ILL);

        repeat (3) @(posedge clk);
        #1;
        chk(0, "scoreboard_drained", 64'(q0.size()), 64'd0);
        chk(1, "scoreboard_drained", 64'(q1.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
